ft232_tx_framer: RTL and testbench



---
 rtl/ft232_pkg.sv | 24 ++
 rtl/ft232_byte_serializer.sv | 45 ++++
 rtl/ft232_tx_framer.sv | 160 ++++++++++++++++
 tb/tb_ft232_tx_framer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft232_pkg.sv
// Shared types and constants for the FT232H transmit framer.
package ft232_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_CHAN,
    ST_CNT,
    ST_PAYLOAD,
    ST_CSUM,
    ST_TAIL
  } state_e;

  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;
  localparam logic [7:0] TAIL_DEF = 8'h0D;

  // Header(2) + channel + count + checksum + tail framing the payload bytes.
  function automatic int frame_len(input int num_ch, input int sample_w);
    return 6 + num_ch * (sample_w / 8);
  endfunction

endpackage

// File: rtl/ft232_byte_serializer.sv
// Splits one SAMPLE_W word into bytes, MSB first, with load/next/empty handshake.
module ft232_byte_serializer
  import ft232_pkg::*;
#(
  parameter int SAMPLE_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                next,
  input  logic [SAMPLE_W-1:0] word,
  output logic [7:0]          head,
  output logic                empty
);

  localparam int NB = SAMPLE_W / 8;
  localparam int CW = $clog2(NB + 1);

  logic [SAMPLE_W-1:0] sreg;
  logic [CW-1:0]       cnt;

  // While empty the incoming word's MSB is passed through, so a load also
  // emits the first byte and only the remaining NB-1 bytes are held.
  assign empty = (cnt == '0);
  assign head  = empty ? word[SAMPLE_W-1 -: 8] : sreg[SAMPLE_W-1 -: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(NB - 1);
    end else if (next && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sreg <= word << 8;
    end else if (next) begin
      sreg <= sreg << 8;
    end
  end

endmodule

// File: rtl/ft232_tx_framer.sv
// Frames NUM_CH samples as HDR0 HDR1 CHAN CNT PAYLOAD CSUM TAIL and writes the
// stream to the FT232H 245-synchronous FIFO write port.
module ft232_tx_framer
  import ft232_pkg::*;
#(
  parameter int         NUM_CH   = 32,
  parameter int         SAMPLE_W = 24,
  parameter logic [7:0] HDR0     = HDR0_DEF,
  parameter logic [7:0] HDR1     = HDR1_DEF,
  parameter logic [7:0] TAIL     = TAIL_DEF
) (
  input  logic                ft232_clk,
  input  logic                clk_rst,
  input  logic                frame_req,
  input  logic [7:0]          channel_num,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                s_ready,
  input  logic                ft_txe_n,
  output logic                ft_wr_n,
  output logic [7:0]          ft_data,
  output logic                busy,
  output logic                frame_done,
  output logic                req_drop
);

  localparam logic [7:0] CNT_BYTE = 8'(NUM_CH);

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_e     state, state_n;
  logic [7:0] data_n, csum, csum_n, chan, chan_n, samp_left, left_n;
  logic       wr_n_n, busy_n, done_n, drop_n;
  logic       acc, fetch;
  logic       ser_load, ser_next, ser_empty;
  logic [7:0] ser_head;

  assign acc = !ft_wr_n && !ft_txe_n;

  ft232_byte_serializer #(.SAMPLE_W(SAMPLE_W)) u_ser (
    .clk   (ft232_clk),
    .rst   (clk_rst),
    .load  (ser_load),
    .next  (ser_next),
    .word  (s_data),
    .head  (ser_head),
    .empty (ser_empty)
  );

  always_comb begin
    state_n  = state;
    data_n   = ft_data;
    wr_n_n   = ft_wr_n;
    busy_n   = busy;
    done_n   = 1'b0;
    drop_n   = frame_req && (state != ST_IDLE);
    csum_n   = csum;
    chan_n   = chan;
    left_n   = samp_left;
    s_ready  = 1'b0;
    ser_load = 1'b0;
    ser_next = 1'b0;
    fetch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_req) begin
          chan_n  = channel_num;
          busy_n  = 1'b1;
          data_n  = HDR0;
          wr_n_n  = 1'b0;
          csum_n  = 8'h00;
          left_n  = CNT_BYTE;
          state_n = ST_HDR0;
        end
      end
      ST_HDR0: if (acc) begin
        data_n  = HDR1;
        state_n = ST_HDR1;
      end
      ST_HDR1: if (acc) begin
        data_n  = chan;
        csum_n  = csum_add(csum, chan);
        state_n = ST_CHAN;
      end
      ST_CHAN: if (acc) begin
        data_n  = CNT_BYTE;
        csum_n  = csum_add(csum, CNT_BYTE);
        state_n = ST_CNT;
      end
      ST_CNT: if (acc) begin
        state_n = ST_PAYLOAD;
        fetch   = 1'b1;
      end
      ST_PAYLOAD: fetch = ft_wr_n || acc;
      ST_CSUM: if (acc) begin
        data_n  = TAIL;
        state_n = ST_TAIL;
      end
      ST_TAIL: if (acc) begin
        wr_n_n  = 1'b1;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // The output slot is free: present the next payload byte, stall, or move to the checksum.
    if (fetch && !clk_rst) begin
      if (!ser_empty) begin
        data_n   = ser_head;
        wr_n_n   = 1'b0;
        ser_next = 1'b1;
        csum_n   = csum_add(csum, ser_head);
      end else if (samp_left != 8'h00) begin
        if (s_valid) begin
          s_ready  = 1'b1;
          ser_load = 1'b1;
          data_n   = ser_head;
          wr_n_n   = 1'b0;
          csum_n   = csum_add(csum, ser_head);
          left_n   = samp_left - 8'h01;
        end else begin
          wr_n_n = 1'b1;
        end
      end else begin
        data_n  = csum;
        wr_n_n  = 1'b0;
        state_n = ST_CSUM;
      end
    end
  end

  always_ff @(posedge ft232_clk) begin
    if (clk_rst) begin
      state      <= ST_IDLE;
      ft_wr_n    <= 1'b1;
      ft_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      req_drop   <= 1'b0;
      csum       <= 8'h00;
      chan       <= 8'h00;
      samp_left  <= 8'h00;
    end else begin
      state      <= state_n;
      ft_wr_n    <= wr_n_n;
      ft_data    <= data_n;
      busy       <= busy_n;
      frame_done <= done_n;
      req_drop   <= drop_n;
      csum       <= csum_n;
      chan       <= chan_n;
      samp_left  <= left_n;
    end
  end

endmodule

// File: tb/tb_ft232_tx_framer.sv
// Bench for ft232_tx_framer: randomized frames checked against a byte-list reference model.
module tb_ft232_tx_framer;
  import ft232_pkg::*;

  localparam int NUM_CH   = 32;
  localparam int SAMPLE_W = 24;
  localparam int NB       = SAMPLE_W / 8;

  logic                ft232_clk = 1'b0;
  logic                clk_rst = 1'b1;
  logic                frame_req = 1'b0;
  logic [7:0]          channel_num = 8'h00;
  logic                s_valid = 1'b0;
  logic [SAMPLE_W-1:0] s_data = '0;
  logic                s_ready;
  logic                ft_txe_n = 1'b0;
  logic                ft_wr_n;
  logic [7:0]          ft_data;
  logic                busy;
  logic                frame_done;
  logic                req_drop;

  int checks = 0;
  int errors = 0;

  logic [SAMPLE_W-1:0] samp [NUM_CH];
  logic [7:0]          got [$];
  logic [7:0]          exp [$];

  int   done_cnt = 0, drop_cnt = 0, stall_err = 0, gap_err = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic stop, timeout, first_wr_n, first_busy, rst_wr_n, rst_busy;
  logic [7:0] first_data;
  int cfg_txe, cfg_valid, cfg_gap, cfg_drop, cfg_rst, run_gb, run_db;
  int drv_idx, drv_gap, txe_c, w_cyc, w_after;
  logic w_dropped;

  ft232_tx_framer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) dut (
    .ft232_clk   (ft232_clk),
    .clk_rst     (clk_rst),
    .frame_req   (frame_req),
    .channel_num (channel_num),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .ft_txe_n    (ft_txe_n),
    .ft_wr_n     (ft_wr_n),
    .ft_data     (ft_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .req_drop    (req_drop)
  );

  always #5 ft232_clk = ~ft232_clk;

  // Observe the bus 1 time unit before each rising edge.
  always @(negedge ft232_clk) begin
    #4;
    if (!ft_wr_n && !ft_txe_n) got.push_back(ft_data);
    if (frame_done) done_cnt++;
    if (req_drop) drop_cnt++;
    if (prev_stall && (ft_wr_n || ft_data != prev_data)) stall_err++;
    prev_stall = !ft_wr_n && ft_txe_n && !clk_rst;
    prev_data  = ft_data;
  end

  task automatic build_exp(input logic [7:0] chan);
    int sum;
    int v;
    exp.delete();
    exp.push_back(8'hAA);
    exp.push_back(8'h55);
    exp.push_back(chan);
    exp.push_back(8'(NUM_CH));
    sum = int'(chan) + NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int b = NB - 1; b >= 0; b--) begin
        v = int'((samp[i] >> (8 * b)) & 24'hFF);
        exp.push_back(8'(v));
        sum += v;
      end
    end
    exp.push_back(8'(sum % 256));
    exp.push_back(8'h0D);
  endtask

  task automatic run_frame(input logic [7:0] chan, input int txe_mode, input int valid_mode,
                           input int gap_at, input int drop_at, input int rst_at);
    cfg_txe = txe_mode; cfg_valid = valid_mode; cfg_gap = gap_at;
    cfg_drop = drop_at; cfg_rst = rst_at;
    run_gb = int'(got.size());
    run_db = done_cnt;
    stop = 1'b0;
    timeout = 1'b0;
    @(negedge ft232_clk);
    frame_req = 1'b1;
    channel_num = chan;
    @(negedge ft232_clk);
    frame_req = 1'b0;
    channel_num = 8'($urandom);
    #1;
    first_wr_n = ft_wr_n;
    first_data = ft_data;
    first_busy = busy;
    fork
      begin
        drv_idx = 0;
        drv_gap = 0;
        while (!stop) begin
          if (drv_idx == cfg_gap && drv_gap < 10) begin
            s_valid = 1'b0;
            drv_gap++;
            if (drv_gap > 5 && ft_wr_n !== 1'b1) gap_err++;
          end else if (drv_idx < NUM_CH && (cfg_valid == 0 || $urandom_range(0, 3) != 0)) begin
            s_valid = 1'b1;
            s_data  = samp[drv_idx];
          end else begin
            s_valid = 1'b0;
            s_data  = SAMPLE_W'($urandom);
          end
          #1;
          if (s_valid && s_ready === 1'b1) drv_idx++;
          @(negedge ft232_clk);
        end
        s_valid = 1'b0;
      end
      begin
        txe_c = 0;
        while (!stop) begin
          case (cfg_txe)
            0:       ft_txe_n = 1'b0;
            1:       ft_txe_n = (txe_c % 5) < 3;
            default: ft_txe_n = 1'($urandom_range(0, 1));
          endcase
          txe_c++;
          @(negedge ft232_clk);
        end
        ft_txe_n = 1'b0;
      end
      begin
        w_cyc = 0;
        w_after = -1;
        w_dropped = 1'b0;
        while (!stop) begin
          @(negedge ft232_clk);
          w_cyc++;
          frame_req = 1'b0;
          if (cfg_drop > 0 && !w_dropped && int'(got.size()) - run_gb >= cfg_drop) begin
            frame_req = 1'b1;
            channel_num = 8'h77;
            w_dropped = 1'b1;
          end
          if (cfg_rst > 0 && int'(got.size()) - run_gb >= cfg_rst) begin
            clk_rst = 1'b1;
            @(posedge ft232_clk);
            #1;
            rst_wr_n = ft_wr_n;
            rst_busy = busy;
            @(negedge ft232_clk);
            clk_rst = 1'b0;
            stop = 1'b1;
          end else if (done_cnt > run_db && w_after < 0) begin
            w_after = w_cyc;
          end
          if (w_after >= 0 && w_cyc - w_after >= 20) stop = 1'b1;
          if (w_cyc >= 4000) begin
            timeout = 1'b1;
            stop = 1'b1;
          end
        end
        frame_req = 1'b0;
      end
    join
  endtask

  task automatic test_reset();
    s_valid = 1'b1;
    repeat (3) @(negedge ft232_clk);
    #1;
    checks++; if (ft_wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n got %b want 1", ft_wr_n); end
    checks++; if (ft_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h want 00", ft_data); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    checks++; if (req_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", req_drop); end
    s_valid = 1'b0;
    clk_rst = 1'b0;
    repeat (3) @(negedge ft232_clk);
    #1;
    checks++; if (ft_wr_n !== 1'b1) begin errors++; $display("FAIL idle_wr_n got %b want 1", ft_wr_n); end
  endtask

  task automatic test_nominal();
    int sb;
    for (int i = 0; i < NUM_CH; i++) samp[i] = SAMPLE_W'(i + 1);
    build_exp(8'h05);
    sb = stall_err;
    run_frame(8'h05, 0, 0, -1, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL nominal_timeout got 1 want 0"); end
    checks++; if (first_wr_n !== 1'b0) begin errors++; $display("FAIL first_wr_n got %b want 0", first_wr_n); end
    checks++; if (first_data !== 8'hAA) begin errors++; $display("FAIL first_data got %02h want AA", first_data); end
    checks++; if (first_busy !== 1'b1) begin errors++; $display("FAIL first_busy got %b want 1", first_busy); end
    checks++;
    if (int'(got.size()) - run_gb != frame_len(NUM_CH, SAMPLE_W)) begin
      errors++; $display("FAIL nominal_len got %0d want %0d", int'(got.size()) - run_gb, frame_len(NUM_CH, SAMPLE_W));
    end
    for (int i = 0; i < exp.size() && run_gb + i < int'(got.size()); i++) begin
      checks++;
      if (got[run_gb + i] !== exp[i]) begin errors++; $display("FAIL nominal_byte[%0d] got %02h want %02h", i, got[run_gb + i], exp[i]); end
    end
    if (run_gb + 100 < int'(got.size())) begin
      checks++;
      if (got[run_gb + 100] !== 8'h35) begin errors++; $display("FAIL nominal_csum got %02h want 35", got[run_gb + 100]); end
    end
    checks++; if (done_cnt - run_db != 1) begin errors++; $display("FAIL nominal_done got %0d want 1", done_cnt - run_db); end
    checks++; if (busy !== 1'b0 || ft_wr_n !== 1'b1) begin errors++; $display("FAIL nominal_idle got busy=%b wr_n=%b want 0/1", busy, ft_wr_n); end
    checks++; if (stall_err != sb) begin errors++; $display("FAIL nominal_stall got %0d want 0", stall_err - sb); end
  endtask

  task automatic test_backpressure();
    int sb;
    for (int i = 0; i < NUM_CH; i++) samp[i] = SAMPLE_W'(i + 1);
    build_exp(8'h05);
    sb = stall_err;
    run_frame(8'h05, 1, 0, -1, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL bp_timeout got 1 want 0"); end
    checks++;
    if (int'(got.size()) - run_gb != exp.size()) begin errors++; $display("FAIL bp_len got %0d want %0d", int'(got.size()) - run_gb, exp.size()); end
    for (int i = 0; i < exp.size() && run_gb + i < int'(got.size()); i++) begin
      checks++;
      if (got[run_gb + i] !== exp[i]) begin errors++; $display("FAIL bp_byte[%0d] got %02h want %02h", i, got[run_gb + i], exp[i]); end
    end
    checks++; if (stall_err != sb) begin errors++; $display("FAIL bp_stall_hold got %0d want 0", stall_err - sb); end
    checks++; if (done_cnt - run_db != 1) begin errors++; $display("FAIL bp_done got %0d want 1", done_cnt - run_db); end
  endtask

  task automatic test_underflow();
    int ge;
    for (int i = 0; i < NUM_CH; i++) samp[i] = SAMPLE_W'(i + 1);
    build_exp(8'h05);
    ge = gap_err;
    run_frame(8'h05, 0, 0, 7, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL uf_timeout got 1 want 0"); end
    checks++; if (gap_err != ge) begin errors++; $display("FAIL uf_gap_wr_n got %0d low cycles want 0", gap_err - ge); end
    checks++;
    if (int'(got.size()) - run_gb != exp.size()) begin errors++; $display("FAIL uf_len got %0d want %0d", int'(got.size()) - run_gb, exp.size()); end
    for (int i = 0; i < exp.size() && run_gb + i < int'(got.size()); i++) begin
      checks++;
      if (got[run_gb + i] !== exp[i]) begin errors++; $display("FAIL uf_byte[%0d] got %02h want %02h", i, got[run_gb + i], exp[i]); end
    end
  endtask

  task automatic test_checksum_wrap();
    for (int i = 0; i < NUM_CH; i++) samp[i] = '1;
    build_exp(8'hFF);
    run_frame(8'hFF, 0, 0, -1, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL wrap_timeout got 1 want 0"); end
    checks++;
    if (int'(got.size()) - run_gb != exp.size()) begin errors++; $display("FAIL wrap_len got %0d want %0d", int'(got.size()) - run_gb, exp.size()); end
    for (int i = 0; i < exp.size() && run_gb + i < int'(got.size()); i++) begin
      checks++;
      if (got[run_gb + i] !== exp[i]) begin errors++; $display("FAIL wrap_byte[%0d] got %02h want %02h", i, got[run_gb + i], exp[i]); end
    end
    if (run_gb + 100 < int'(got.size())) begin
      checks++;
      if (got[run_gb + 100] !== 8'hBF) begin errors++; $display("FAIL wrap_csum got %02h want BF", got[run_gb + 100]); end
    end
  endtask

  task automatic test_overlap();
    int dd;
    logic [7:0] ch;
    // Request mid-frame, then a request coinciding with tail acceptance.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NUM_CH; i++) samp[i] = SAMPLE_W'($urandom);
      ch = 8'($urandom);
      build_exp(ch);
      dd = drop_cnt;
      run_frame(ch, 0, 0, -1, (k == 0) ? 30 : 101, 0);
      checks++; if (timeout) begin errors++; $display("FAIL ovl%0d_timeout got 1 want 0", k); end
      checks++; if (drop_cnt - dd != 1) begin errors++; $display("FAIL ovl%0d_req_drop got %0d want 1", k, drop_cnt - dd); end
      checks++; if (done_cnt - run_db != 1) begin errors++; $display("FAIL ovl%0d_done got %0d want 1", k, done_cnt - run_db); end
      checks++;
      if (int'(got.size()) - run_gb != exp.size()) begin errors++; $display("FAIL ovl%0d_len got %0d want %0d", k, int'(got.size()) - run_gb, exp.size()); end
      for (int i = 0; i < exp.size() && run_gb + i < int'(got.size()); i++) begin
        checks++;
        if (got[run_gb + i] !== exp[i]) begin errors++; $display("FAIL ovl%0d_byte[%0d] got %02h want %02h", k, i, got[run_gb + i], exp[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int gb2;
    for (int i = 0; i < NUM_CH; i++) samp[i] = SAMPLE_W'($urandom);
    run_frame(8'h3C, 0, 0, -1, 0, 40);
    checks++; if (timeout) begin errors++; $display("FAIL rstmid_timeout got 1 want 0"); end
    checks++; if (rst_wr_n !== 1'b1) begin errors++; $display("FAIL rstmid_wr_n got %b want 1", rst_wr_n); end
    checks++; if (rst_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", rst_busy); end
    checks++; if (done_cnt != run_db) begin errors++; $display("FAIL rstmid_done got %0d want 0", done_cnt - run_db); end
    gb2 = int'(got.size());
    repeat (6) @(negedge ft232_clk);
    checks++; if (int'(got.size()) != gb2) begin errors++; $display("FAIL rstmid_quiet got %0d bytes want 0", int'(got.size()) - gb2); end
    for (int i = 0; i < NUM_CH; i++) samp[i] = SAMPLE_W'($urandom);
    build_exp(8'hC3);
    run_frame(8'hC3, 0, 0, -1, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL postrst_timeout got 1 want 0"); end
    checks++;
    if (int'(got.size()) - run_gb != exp.size()) begin errors++; $display("FAIL postrst_len got %0d want %0d", int'(got.size()) - run_gb, exp.size()); end
    for (int i = 0; i < exp.size() && run_gb + i < int'(got.size()); i++) begin
      checks++;
      if (got[run_gb + i] !== exp[i]) begin errors++; $display("FAIL postrst_byte[%0d] got %02h want %02h", i, got[run_gb + i], exp[i]); end
    end
  endtask

  task automatic test_random();
    int sb;
    logic [7:0] ch;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NUM_CH; i++) samp[i] = SAMPLE_W'($urandom);
      ch = 8'($urandom);
      build_exp(ch);
      sb = stall_err;
      run_frame(ch, 2, 1, -1, 0, 0);
      checks++; if (timeout) begin errors++; $display("FAIL rnd%0d_timeout got 1 want 0", k); end
      checks++; if (stall_err != sb) begin errors++; $display("FAIL rnd%0d_stall_hold got %0d want 0", k, stall_err - sb); end
      checks++; if (done_cnt - run_db != 1) begin errors++; $display("FAIL rnd%0d_done got %0d want 1", k, done_cnt - run_db); end
      checks++;
      if (int'(got.size()) - run_gb != exp.size()) begin errors++; $display("FAIL rnd%0d_len got %0d want %0d", k, int'(got.size()) - run_gb, exp.size()); end
      for (int i = 0; i < exp.size() && run_gb + i < int'(got.size()); i++) begin
        checks++;
        if (got[run_gb + i] !== exp[i]) begin errors++; $display("FAIL rnd%0d_byte[%0d] got %02h want %02h", k, i, got[run_gb + i], exp[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_underflow();
    test_checksum_wrap();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
